// File: rtl/coef_loader.sv
// Coefficient RAM loader: streams N host words into the left or right RAM,
// reads them back and compares XOR checksums, flagging err on mismatch.
module coef_loader #(
  parameter int DW = 36,
  parameter int AW = 14
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          chsel,
  input  logic [AW:0]   nwords,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [AW-1:0] addrLrw,
  output logic [AW-1:0] addrRrw,
  output logic [DW-1:0] datainLrw,
  output logic [DW-1:0] datainRrw,
  output logic          weL,
  output logic          weR,
  input  logic [DW-1:0] dataoutLrw,
  input  logic [DW-1:0] dataoutRrw,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_VRD, S_VCAP, S_DONE} state_e;

  localparam logic [AW:0]   MAXN  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   N_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] K_ONE = {{(AW-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic          ch_q, ch_d;
  logic [AW:0]   n_q, n_d;
  logic [AW-1:0] k_q, k_d;
  logic [DW-1:0] wsum_q, wsum_d, rsum_q, rsum_d;
  logic          err_q, err_d, done_q, done_d, busy_q, busy_d;
  logic [AW-1:0] addrl_q, addrl_d, addrr_q, addrr_d;
  logic [DW-1:0] datl_q, datl_d, datr_q, datr_d;
  logic          wel_q, wel_d, wer_q, wer_d;

  logic [AW-1:0] a_s;
  logic [DW-1:0] dat_s;
  logic          we_s;
  logic          last_k_s;
  logic [DW-1:0] dout_sel_s;

  assign din_ready = (state_q == S_LOAD);

  // Next-state, checksum and channel-output logic
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    n_d     = n_q;
    k_d     = k_q;
    wsum_d  = wsum_q;
    rsum_d  = rsum_q;
    err_d   = err_q;
    done_d  = 1'b0;
    a_s     = '0;
    dat_s   = '0;
    we_s    = 1'b0;
    last_k_s   = (({1'b0, k_q} + N_ONE) == n_q);
    dout_sel_s = ch_q ? dataoutRrw : dataoutLrw;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ch_d   = chsel;
          n_d    = (nwords > MAXN) ? MAXN : nwords;
          k_d    = '0;
          wsum_d = '0;
          rsum_d = '0;
          err_d  = 1'b0;
          if (nwords == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (din_valid) begin
          a_s    = k_q;
          dat_s  = din;
          we_s   = 1'b1;
          wsum_d = wsum_q ^ din;
          if (last_k_s) begin
            k_d     = '0;
            state_d = S_VRD;
          end else begin
            k_d = k_q + K_ONE;
          end
        end else begin
          // Bubble: keep the last presented address and data, no write.
          a_s   = ch_q ? addrr_q : addrl_q;
          dat_s = ch_q ? datr_q : datl_q;
        end
      end
      S_VRD: begin
        a_s     = k_q;
        state_d = S_VCAP;
      end
      S_VCAP: begin
        rsum_d = rsum_q ^ dout_sel_s;
        if (last_k_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = (wsum_q != rsum_d);
        end else begin
          k_d     = k_q + K_ONE;
          a_s     = k_q + K_ONE;
          state_d = S_VRD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    addrl_d = ch_d ? '0 : a_s;
    addrr_d = ch_d ? a_s : '0;
    datl_d  = ch_d ? '0 : dat_s;
    datr_d  = ch_d ? dat_s : '0;
    wel_d   = ch_d ? 1'b0 : we_s;
    wer_d   = ch_d ? we_s : 1'b0;
  end

  // State and registered-output update
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ch_q    <= 1'b0;
      n_q     <= '0;
      k_q     <= '0;
      wsum_q  <= '0;
      rsum_q  <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      addrl_q <= '0;
      addrr_q <= '0;
      datl_q  <= '0;
      datr_q  <= '0;
      wel_q   <= 1'b0;
      wer_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      n_q     <= n_d;
      k_q     <= k_d;
      wsum_q  <= wsum_d;
      rsum_q  <= rsum_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      addrl_q <= addrl_d;
      addrr_q <= addrr_d;
      datl_q  <= datl_d;
      datr_q  <= datr_d;
      wel_q   <= wel_d;
      wer_q   <= wer_d;
    end
  end

  assign addrLrw   = addrl_q;
  assign addrRrw   = addrr_q;
  assign datainLrw = datl_q;
  assign datainRrw = datr_q;
  assign weL       = wel_q;
  assign weR       = wer_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
